// File: rtl/fetch_stage_if.sv
// Bundle between the fetch stage, instruction memory and the controller/ID datapath.
// The master side is the fetch stage; the slave side is the surrounding pipeline.
interface fetch_stage_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 32
);
  logic               stall;
  logic               killF;
  logic [1:0]         PCSrc;
  logic [PC_W-1:0]    branch_target;
  logic [PC_W-1:0]    jump_target;
  logic [PC_W-1:0]    return_addr;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] IDInstr;
  logic [3:0]         IDOpcode;
  logic [PC_W-1:0]    IDPCPlus1;
  logic               IDValid;
  logic [CNT_W-1:0]   fetch_count;
  logic [CNT_W-1:0]   bubble_count;

  modport master (
    input  stall, killF, PCSrc, branch_target, jump_target, return_addr, imem_data,
    output imem_addr, IDInstr, IDOpcode, IDPCPlus1, IDValid, fetch_count, bubble_count
  );

  modport slave (
    output stall, killF, PCSrc, branch_target, jump_target, return_addr, imem_data,
    input  imem_addr, IDInstr, IDOpcode, IDPCPlus1, IDValid, fetch_count, bubble_count
  );
endinterface

// File: rtl/fetch_stage.sv
// IF stage + IF/ID register: PC drives imem_addr combinationally, fetched word lands in IF/ID one clock later.
// No handshake: stall freezes PC and IF/ID, killF squashes the IF word into a bubble and redirects the PC.
module fetch_stage #(
  parameter int                 PC_W      = 16,
  parameter int                 INSTR_W   = 16,
  parameter logic [PC_W-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
  parameter int                 CNT_W     = 32
) (
  input logic           clk,
  input logic           reset,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_RETURN = 2'b11
  } pc_src_e;

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic [PC_W-1:0]    id_pc_plus1_q, id_pc_plus1_d;
  logic               id_valid_q, id_valid_d;
  logic [CNT_W-1:0]   fetch_count_q, fetch_count_d;
  logic [CNT_W-1:0]   bubble_count_q, bubble_count_d;
  logic [PC_W-1:0]    pc_plus1;
  pc_src_e            pc_src;

  assign pc_plus1 = pc_q + PC_W'(1);
  assign pc_src   = pc_src_e'(bus.PCSrc);

  always_comb begin
    pc_d           = pc_q;
    id_instr_d     = id_instr_q;
    id_pc_plus1_d  = id_pc_plus1_q;
    id_valid_d     = id_valid_q;
    fetch_count_d  = fetch_count_q;
    bubble_count_d = bubble_count_q;

    if (bus.stall) begin
      // ID operands are stale during a load-use stall; the redirect is re-evaluated later.
    end else if (bus.killF) begin
      id_instr_d     = NOP_INSTR;
      id_valid_d     = 1'b0;
      id_pc_plus1_d  = '0;
      bubble_count_d = bubble_count_q + CNT_W'(1);
      unique case (pc_src)
        PC_SEQ:    pc_d = id_pc_plus1_q;  // not-taken: refetch the squashed fall-through
        PC_BRANCH: pc_d = bus.branch_target;
        PC_JUMP:   pc_d = bus.jump_target;
        PC_RETURN: pc_d = bus.return_addr;
        default:   pc_d = id_pc_plus1_q;
      endcase
    end else begin
      id_instr_d    = bus.imem_data;
      id_pc_plus1_d = pc_plus1;
      id_valid_d    = 1'b1;
      fetch_count_d = fetch_count_q + CNT_W'(1);
      pc_d          = pc_plus1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q           <= RESET_PC;
      id_instr_q     <= NOP_INSTR;
      id_pc_plus1_q  <= '0;
      id_valid_q     <= 1'b0;
      fetch_count_q  <= '0;
      bubble_count_q <= '0;
    end else begin
      pc_q           <= pc_d;
      id_instr_q     <= id_instr_d;
      id_pc_plus1_q  <= id_pc_plus1_d;
      id_valid_q     <= id_valid_d;
      fetch_count_q  <= fetch_count_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign bus.imem_addr    = pc_q;
  assign bus.IDInstr      = id_instr_q;
  assign bus.IDOpcode     = id_instr_q[INSTR_W-1 -: 4];
  assign bus.IDPCPlus1    = id_pc_plus1_q;
  assign bus.IDValid      = id_valid_q;
  assign bus.fetch_count  = fetch_count_q;
  assign bus.bubble_count = bubble_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stall, branch/jump/return redirects, wrap and reset.
module tb_fetch_stage;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [15:0] mem [0:65535];

  fetch_stage_if #(.PC_W(16), .INSTR_W(16), .CNT_W(32)) bus ();

  fetch_stage #(
    .PC_W(16), .INSTR_W(16), .RESET_PC(16'h0000), .NOP_INSTR(16'h0000), .CNT_W(32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.imem_data = mem[bus.imem_addr];

  // Instruction image: A,B,C,D at 0..3, otherwise 0x1000 + address.
  function automatic logic [15:0] word_at(input logic [15:0] a);
    case (a)
      16'd0:   word_at = 16'hA0A0;
      16'd1:   word_at = 16'hB0B1;
      16'd2:   word_at = 16'hC0C2;
      16'd3:   word_at = 16'hD0D3;
      default: word_at = 16'h1000 + a;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_ctrl();
    bus.stall = 1'b0; bus.killF = 1'b0; bus.PCSrc = 2'b00;
    bus.branch_target = '0; bus.jump_target = '0; bus.return_addr = '0;
  endtask

  task automatic do_reset();
    clear_ctrl();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.imem_addr !== 16'h0000) begin failures++; $display("FAIL reset_pc got=%h exp=%h", bus.imem_addr, 16'h0000); end
    checks++; if (bus.IDInstr !== 16'h0000) begin failures++; $display("FAIL reset_instr got=%h exp=%h", bus.IDInstr, 16'h0000); end
    checks++; if (bus.IDValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.IDValid); end
    checks++; if (bus.IDPCPlus1 !== 16'h0000) begin failures++; $display("FAIL reset_pcp1 got=%h exp=%h", bus.IDPCPlus1, 16'h0000); end
    checks++; if (bus.fetch_count !== 32'd0 || bus.bubble_count !== 32'd0) begin failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", bus.fetch_count, bus.bubble_count); end
  endtask

  task automatic test_sequential();
    logic [15:0] exp_w [0:3];
    exp_w[0] = 16'hA0A0; exp_w[1] = 16'hB0B1; exp_w[2] = 16'hC0C2; exp_w[3] = 16'hD0D3;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (bus.IDInstr !== exp_w[i]) begin failures++; $display("FAIL seq_instr[%0d] got=%h exp=%h", i, bus.IDInstr, exp_w[i]); end
      checks++; if (bus.IDOpcode !== exp_w[i][15:12]) begin failures++; $display("FAIL seq_opcode[%0d] got=%h exp=%h", i, bus.IDOpcode, exp_w[i][15:12]); end
      checks++; if (bus.IDPCPlus1 !== 16'(i + 1)) begin failures++; $display("FAIL seq_pcp1[%0d] got=%h exp=%h", i, bus.IDPCPlus1, 16'(i + 1)); end
      checks++; if (bus.IDValid !== 1'b1) begin failures++; $display("FAIL seq_valid[%0d] got=%b exp=1", i, bus.IDValid); end
    end
    checks++; if (bus.fetch_count !== 32'd4) begin failures++; $display("FAIL seq_fetch_count got=%0d exp=4", bus.fetch_count); end
    checks++; if (bus.imem_addr !== 16'd4) begin failures++; $display("FAIL seq_pc got=%h exp=%h", bus.imem_addr, 16'd4); end
  endtask

  task automatic test_stall();
    do_reset();
    step(); step();
    // Stall with a pending redirect: everything must hold.
    bus.stall = 1'b1; bus.killF = 1'b1; bus.PCSrc = 2'b01; bus.branch_target = 16'd20;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (bus.IDInstr !== 16'hB0B1) begin failures++; $display("FAIL stall_instr[%0d] got=%h exp=%h", i, bus.IDInstr, 16'hB0B1); end
      checks++; if (bus.imem_addr !== 16'd2) begin failures++; $display("FAIL stall_pc[%0d] got=%h exp=%h", i, bus.imem_addr, 16'd2); end
      checks++; if (bus.fetch_count !== 32'd2 || bus.bubble_count !== 32'd0) begin failures++; $display("FAIL stall_counts[%0d] got=%0d/%0d exp=2/0", i, bus.fetch_count, bus.bubble_count); end
      checks++; if (bus.IDPCPlus1 !== 16'd2 || bus.IDValid !== 1'b1) begin failures++; $display("FAIL stall_pcp1_valid[%0d] got=%h/%b exp=0002/1", i, bus.IDPCPlus1, bus.IDValid); end
    end
    clear_ctrl();
    step();
    checks++; if (bus.IDInstr !== 16'hC0C2) begin failures++; $display("FAIL stall_resume got=%h exp=%h", bus.IDInstr, 16'hC0C2); end
    checks++; if (bus.imem_addr !== 16'd3 || bus.fetch_count !== 32'd3) begin failures++; $display("FAIL stall_resume_pc_cnt got=%h/%0d exp=0003/3", bus.imem_addr, bus.fetch_count); end
  endtask

  task automatic test_branch_taken();
    do_reset();
    for (int i = 0; i < 6; i++) step();
    checks++; if (bus.IDInstr !== 16'h1005 || bus.imem_addr !== 16'd6) begin failures++; $display("FAIL bt_setup got=%h/%h exp=1005/0006", bus.IDInstr, bus.imem_addr); end
    bus.killF = 1'b1; bus.PCSrc = 2'b01; bus.branch_target = 16'd20;
    step();
    checks++; if (bus.IDInstr !== 16'h0000 || bus.IDValid !== 1'b0) begin failures++; $display("FAIL bt_bubble got=%h/%b exp=0000/0", bus.IDInstr, bus.IDValid); end
    checks++; if (bus.imem_addr !== 16'd20) begin failures++; $display("FAIL bt_target got=%h exp=%h", bus.imem_addr, 16'd20); end
    checks++; if (bus.bubble_count !== 32'd1 || bus.fetch_count !== 32'd6) begin failures++; $display("FAIL bt_counts got=%0d/%0d exp=6/1", bus.fetch_count, bus.bubble_count); end
    checks++; if (bus.IDPCPlus1 !== 16'd0) begin failures++; $display("FAIL bt_pcp1 got=%h exp=0000", bus.IDPCPlus1); end
    clear_ctrl();
    step();
    checks++; if (bus.IDInstr !== 16'h1014 || bus.IDPCPlus1 !== 16'd21 || bus.IDValid !== 1'b1) begin failures++; $display("FAIL bt_fetch got=%h/%h/%b exp=1014/0015/1", bus.IDInstr, bus.IDPCPlus1, bus.IDValid); end
  endtask

  task automatic test_branch_not_taken();
    do_reset();
    for (int i = 0; i < 6; i++) step();
    bus.killF = 1'b1; bus.PCSrc = 2'b00; bus.branch_target = 16'd20;
    step();
    checks++; if (bus.imem_addr !== 16'd6 || bus.IDValid !== 1'b0) begin failures++; $display("FAIL bnt_refetch got=%h/%b exp=0006/0", bus.imem_addr, bus.IDValid); end
    clear_ctrl();
    step();
    checks++; if (bus.IDInstr !== 16'h1006 || bus.IDPCPlus1 !== 16'd7) begin failures++; $display("FAIL bnt_fetch got=%h/%h exp=1006/0007", bus.IDInstr, bus.IDPCPlus1); end
    checks++; if (bus.bubble_count !== 32'd1 || bus.fetch_count !== 32'd7) begin failures++; $display("FAIL bnt_counts got=%0d/%0d exp=7/1", bus.fetch_count, bus.bubble_count); end
  endtask

  task automatic test_call_return();
    do_reset();
    for (int i = 0; i < 9; i++) step();
    checks++; if (bus.IDInstr !== 16'h1008 || bus.IDPCPlus1 !== 16'd9) begin failures++; $display("FAIL call_link got=%h/%h exp=1008/0009", bus.IDInstr, bus.IDPCPlus1); end
    bus.killF = 1'b1; bus.PCSrc = 2'b10; bus.jump_target = 16'd40;
    step();
    checks++; if (bus.imem_addr !== 16'd40) begin failures++; $display("FAIL call_target got=%h exp=%h", bus.imem_addr, 16'd40); end
    clear_ctrl();
    step(); step();
    checks++; if (bus.IDInstr !== 16'h1029 || bus.imem_addr !== 16'd42) begin failures++; $display("FAIL call_body got=%h/%h exp=1029/002a", bus.IDInstr, bus.imem_addr); end
    bus.killF = 1'b1; bus.PCSrc = 2'b11; bus.return_addr = 16'd9;
    step();
    checks++; if (bus.imem_addr !== 16'd9 || bus.bubble_count !== 32'd2) begin failures++; $display("FAIL ret_target got=%h/%0d exp=0009/2", bus.imem_addr, bus.bubble_count); end
    clear_ctrl();
    step();
    checks++; if (bus.IDInstr !== 16'h1009 || bus.IDPCPlus1 !== 16'd10 || bus.fetch_count !== 32'd12) begin failures++; $display("FAIL ret_fetch got=%h/%h/%0d exp=1009/000a/12", bus.IDInstr, bus.IDPCPlus1, bus.fetch_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(); step();
    bus.killF = 1'b1; bus.PCSrc = 2'b01; bus.branch_target = 16'd30;
    step();
    bus.PCSrc = 2'b10; bus.jump_target = 16'd50;
    step();
    checks++; if (bus.imem_addr !== 16'd50 || bus.bubble_count !== 32'd2 || bus.IDValid !== 1'b0) begin failures++; $display("FAIL b2b_redirect got=%h/%0d/%b exp=0032/2/0", bus.imem_addr, bus.bubble_count, bus.IDValid); end
    clear_ctrl();
    step();
    checks++; if (bus.IDInstr !== 16'h1032 || bus.fetch_count !== 32'd3) begin failures++; $display("FAIL b2b_fetch got=%h/%0d exp=1032/3", bus.IDInstr, bus.fetch_count); end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    bus.killF = 1'b1; bus.PCSrc = 2'b10; bus.jump_target = 16'hFFFF;
    step();
    checks++; if (bus.imem_addr !== 16'hFFFF) begin failures++; $display("FAIL wrap_setup got=%h exp=ffff", bus.imem_addr); end
    clear_ctrl();
    step();
    checks++; if (bus.imem_addr !== 16'h0000 || bus.IDPCPlus1 !== 16'h0000 || bus.IDInstr !== 16'h0FFF) begin failures++; $display("FAIL wrap got=%h/%h/%h exp=0000/0000/0fff", bus.imem_addr, bus.IDPCPlus1, bus.IDInstr); end
    // Nonzero PCSrc without killF still advances sequentially.
    bus.PCSrc = 2'b01; bus.branch_target = 16'd20;
    step();
    checks++; if (bus.imem_addr !== 16'd1 || bus.IDInstr !== 16'hA0A0) begin failures++; $display("FAIL illegal_pcsrc got=%h/%h exp=0001/a0a0", bus.imem_addr, bus.IDInstr); end
    bus.stall = 1'b1; bus.killF = 1'b1; bus.PCSrc = 2'b01;
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_ctrl();
    checks++; if (bus.imem_addr !== 16'h0000 || bus.IDValid !== 1'b0 || bus.IDInstr !== 16'h0000) begin failures++; $display("FAIL mid_reset got=%h/%b/%h exp=0000/0/0000", bus.imem_addr, bus.IDValid, bus.IDInstr); end
    checks++; if (bus.fetch_count !== 32'd0 || bus.bubble_count !== 32'd0) begin failures++; $display("FAIL mid_reset_counts got=%0d/%0d exp=0/0", bus.fetch_count, bus.bubble_count); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = word_at(16'(i));
    clear_ctrl();
    test_reset();
    test_sequential();
    test_stall();
    test_branch_taken();
    test_branch_not_taken();
    test_call_return();
    test_back_to_back();
    test_wrap_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
